// File: rtl/matcher_pkg.sv
// Shared state encoding, default sizes and helpers for the matcher feeder.
package matcher_pkg;

    localparam int unsigned DEF_INPUT_STREAM_WIDTH = 512;
    localparam int unsigned DEF_DATA_WIDTH         = 64;
    localparam int unsigned DEF_ID_WIDTH           = 16;
    localparam int unsigned DEF_TIMEOUT            = 255;
    localparam int unsigned STAT_W                 = 32;

    typedef enum logic [2:0] {
        ST_LOAD    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_REPORT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    // Outcome of one matcher query as presented on the result port.
    typedef struct packed {
        logic match;
        logic timeout;
    } result_t;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/matcher_window_loader.sv
// Packs record beats into the matcher window slot by slot; slots never
// written since the last clear read as zero.
module matcher_window_loader
    import matcher_pkg::*;
#(
    parameter int unsigned INPUT_STREAM_WIDTH = DEF_INPUT_STREAM_WIDTH,
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          beat_valid,
    input  logic [DATA_WIDTH-1:0]         beat_data,
    input  logic                          clear,
    output logic [INPUT_STREAM_WIDTH-1:0] window,
    output logic                          first_beat_c,
    output logic                          last_slot_c
);

    localparam int unsigned NBEATS = INPUT_STREAM_WIDTH / DATA_WIDTH;
    localparam int unsigned IDX_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    logic [INPUT_STREAM_WIDTH-1:0] window_q, window_d;
    logic [IDX_W-1:0]              beat_idx_q, beat_idx_d;

    assign first_beat_c = (beat_idx_q == '0);
    assign last_slot_c  = (beat_idx_q == IDX_W'(NBEATS - 1));
    assign window       = window_q;

    always_comb begin
        window_d   = window_q;
        beat_idx_d = beat_idx_q;
        if (clear) begin
            window_d   = '0;
            beat_idx_d = '0;
        end else if (beat_valid) begin
            for (int unsigned k = 0; k < NBEATS; k++) begin
                if (beat_idx_q == IDX_W'(k)) begin
                    window_d[k*DATA_WIDTH +: DATA_WIDTH] = beat_data;
                end
            end
            // The index parks on the last slot; the feeder leaves LOAD there.
            if (!last_slot_c) begin
                beat_idx_d = beat_idx_q + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_q   <= '0;
            beat_idx_q <= '0;
        end else begin
            window_q   <= window_d;
            beat_idx_q <= beat_idx_d;
        end
    end

endmodule

// File: rtl/matcher_feeder.sv
// Feeds one record at a time into an external pattern matcher, waits for its
// verdict (or gives up after TIMEOUT cycles) and reports it with a record id.
module matcher_feeder
    import matcher_pkg::*;
#(
    parameter int unsigned INPUT_STREAM_WIDTH = DEF_INPUT_STREAM_WIDTH,
    parameter int unsigned DATA_WIDTH         = DEF_DATA_WIDTH,
    parameter int unsigned ID_WIDTH           = DEF_ID_WIDTH,
    parameter int unsigned TIMEOUT            = DEF_TIMEOUT
) (
    input  logic                          fclk,
    input  logic                          areset,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         cfg_pattern,
    output logic [INPUT_STREAM_WIDTH-1:0] input_stream,
    output logic [DATA_WIDTH-1:0]         compare_data,
    output logic                          filter_result_valid,
    input  logic                          result_valid,
    input  logic                          result_match,
    output logic                          result_reset,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic                          m_match,
    output logic                          m_timeout,
    output logic [ID_WIDTH-1:0]           m_record_id,
    output logic [STAT_W-1:0]             stat_records,
    output logic [STAT_W-1:0]             stat_matches
);

    localparam int unsigned WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    result_t             result_q, result_d;
    logic [ID_WIDTH-1:0] record_id_q, record_id_d;
    logic [DATA_WIDTH-1:0] compare_q, compare_d;
    logic [STAT_W-1:0]   stat_records_q, stat_records_d;
    logic [STAT_W-1:0]   stat_matches_q, stat_matches_d;
    logic                s_ready_q, s_ready_d;
    logic                frv_q, frv_d;
    logic                m_valid_q, m_valid_d;
    logic                result_reset_q, result_reset_d;

    logic beat_acc_c;
    logic load_clear_c;
    logic first_beat_c;
    logic last_slot_c;

    assign beat_acc_c = s_valid && s_ready_q;

    matcher_window_loader #(
        .INPUT_STREAM_WIDTH (INPUT_STREAM_WIDTH),
        .DATA_WIDTH         (DATA_WIDTH)
    ) u_loader (
        .clk          (fclk),
        .rst          (areset),
        .beat_valid   (beat_acc_c),
        .beat_data    (s_data),
        .clear        (load_clear_c),
        .window       (input_stream),
        .first_beat_c (first_beat_c),
        .last_slot_c  (last_slot_c)
    );

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        result_d       = result_q;
        record_id_d    = record_id_q;
        compare_d      = compare_q;
        stat_records_d = stat_records_q;
        stat_matches_d = stat_matches_q;
        load_clear_c   = 1'b0;

        unique case (state_q)
            ST_LOAD: begin
                if (beat_acc_c) begin
                    if (first_beat_c) begin
                        compare_d = cfg_pattern;
                    end
                    if (s_last || last_slot_c) begin
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // A real verdict wins over a timeout landing in the same cycle.
                if (result_valid) begin
                    result_d.match   = result_match;
                    result_d.timeout = 1'b0;
                    state_d          = ST_REPORT;
                end else if (wait_cnt_q == WAIT_W'(TIMEOUT)) begin
                    result_d.match   = 1'b0;
                    result_d.timeout = 1'b1;
                    state_d          = ST_REPORT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            ST_REPORT: begin
                if (m_ready) begin
                    stat_records_d = sat_inc(stat_records_q);
                    if (result_q.match) begin
                        stat_matches_d = sat_inc(stat_matches_q);
                    end
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                load_clear_c = 1'b1;
                record_id_d  = record_id_q + ID_WIDTH'(1);
                result_d     = '0;
                state_d      = ST_LOAD;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Handshake outputs are registered decodes of the upcoming state.
        s_ready_d      = (state_d == ST_LOAD);
        frv_d          = (state_d == ST_ISSUE);
        m_valid_d      = (state_d == ST_REPORT);
        result_reset_d = (state_d == ST_RELEASE);
    end

    always_ff @(posedge fclk or posedge areset) begin
        if (areset) begin
            state_q        <= ST_LOAD;
            wait_cnt_q     <= '0;
            result_q       <= '0;
            record_id_q    <= '0;
            compare_q      <= '0;
            stat_records_q <= '0;
            stat_matches_q <= '0;
            s_ready_q      <= 1'b1;
            frv_q          <= 1'b0;
            m_valid_q      <= 1'b0;
            result_reset_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            result_q       <= result_d;
            record_id_q    <= record_id_d;
            compare_q      <= compare_d;
            stat_records_q <= stat_records_d;
            stat_matches_q <= stat_matches_d;
            s_ready_q      <= s_ready_d;
            frv_q          <= frv_d;
            m_valid_q      <= m_valid_d;
            result_reset_q <= result_reset_d;
        end
    end

    assign s_ready             = s_ready_q;
    assign compare_data        = compare_q;
    assign filter_result_valid = frv_q;
    assign result_reset        = result_reset_q;
    assign m_valid             = m_valid_q;
    assign m_match             = result_q.match;
    assign m_timeout           = result_q.timeout;
    assign m_record_id         = record_id_q;
    assign stat_records        = stat_records_q;
    assign stat_matches        = stat_matches_q;

endmodule

// File: tb/tb_matcher_feeder.sv
// Randomized record-level bench for matcher_feeder with a transaction model of
// window contents, verdict, record id and statistics.
module tb_matcher_feeder;

    localparam int unsigned ISW = 512;
    localparam int unsigned DW  = 64;
    localparam int unsigned IDW = 4;   // small id width so wrap-around is reached quickly
    localparam int unsigned TMO = 40;
    localparam int unsigned NB  = ISW / DW;

    logic           fclk;
    logic           areset;
    logic [DW-1:0]  s_data;
    logic           s_valid;
    logic           s_last;
    logic           s_ready;
    logic [DW-1:0]  cfg_pattern;
    logic [ISW-1:0] input_stream;
    logic [DW-1:0]  compare_data;
    logic           filter_result_valid;
    logic           result_valid;
    logic           result_match;
    logic           result_reset;
    logic           m_valid;
    logic           m_ready;
    logic           m_match;
    logic           m_timeout;
    logic [IDW-1:0] m_record_id;
    logic [31:0]    stat_records;
    logic [31:0]    stat_matches;

    int vectors     = 0;
    int miscompares = 0;
    int exp_id;
    int exp_records;
    int exp_matches;
    logic [DW-1:0] beat_buf [NB];

    matcher_feeder #(
        .INPUT_STREAM_WIDTH (ISW),
        .DATA_WIDTH         (DW),
        .ID_WIDTH           (IDW),
        .TIMEOUT            (TMO)
    ) dut (
        .fclk                (fclk),
        .areset              (areset),
        .s_data              (s_data),
        .s_valid             (s_valid),
        .s_last              (s_last),
        .s_ready             (s_ready),
        .cfg_pattern         (cfg_pattern),
        .input_stream        (input_stream),
        .compare_data        (compare_data),
        .filter_result_valid (filter_result_valid),
        .result_valid        (result_valid),
        .result_match        (result_match),
        .result_reset        (result_reset),
        .m_valid             (m_valid),
        .m_ready             (m_ready),
        .m_match             (m_match),
        .m_timeout           (m_timeout),
        .m_record_id         (m_record_id),
        .stat_records        (stat_records),
        .stat_matches        (stat_matches)
    );

    initial fclk = 1'b0;
    always #5 fclk = ~fclk;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge fclk);
        #1;
    endtask

    // One full record: load, issue, wait (lat<0 means the matcher stays silent), report, release.
    task automatic run_record(input int n, input bit last_on_full, input logic [DW-1:0] pattern,
                              input int lat, input bit mbit, input int rdy_delay, input bit gaps);
        logic [ISW-1:0] exp_win;
        bit exp_tmo;
        bit exp_match;
        int wait_cycles;
        exp_win = '0;
        for (int k = 0; k < n; k++) exp_win[k*DW +: DW] = beat_buf[k];
        exp_tmo     = (lat < 0);
        exp_match   = exp_tmo ? 1'b0 : mbit;
        wait_cycles = exp_tmo ? int'(TMO) + 1 : lat + 1;

        vectors++;
        if (s_ready !== 1'b1 || input_stream !== '0) begin
            miscompares++;
            $display("FAIL load_entry s_ready=%0b window_zero=%0b required 1/1", s_ready, input_stream == '0);
        end

        for (int k = 0; k < n; k++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0; s_data = {$urandom, $urandom}; s_last = 1'b0;
                cfg_pattern = {$urandom, $urandom};
                result_valid = 1'(($urandom_range(0, 1))); result_match = 1'($urandom_range(0, 1));
                step();
                vectors++;
                if (s_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL gap_ready got=%0b required=1", s_ready);
                end
            end
            s_valid = 1'b1;
            s_data  = beat_buf[k];
            s_last  = (k == n - 1) && (n < int'(NB) || last_on_full);
            cfg_pattern = (k == 0) ? pattern : {$urandom, $urandom};
            result_valid = 1'($urandom_range(0, 1)); result_match = 1'($urandom_range(0, 1));
            step();
            if (k < n - 1) begin
                vectors++;
                if (s_ready !== 1'b1 || filter_result_valid !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mid_load s_ready=%0b frv=%0b required 1/0", s_ready, filter_result_valid);
                end
            end
        end

        // ISSUE: keep offering junk beats and a spurious verdict, both must be ignored.
        s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'($urandom_range(0, 1));
        cfg_pattern = {$urandom, $urandom};
        result_valid = 1'($urandom_range(0, 1)); result_match = 1'($urandom_range(0, 1));
        vectors++;
        if (filter_result_valid !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL issue frv=%0b s_ready=%0b m_valid=%0b required 1/0/0", filter_result_valid, s_ready, m_valid);
        end
        vectors++;
        if (input_stream !== exp_win) begin
            miscompares++;
            $display("FAIL window got=%h required=%h", input_stream, exp_win);
        end
        vectors++;
        if (compare_data !== pattern) begin
            miscompares++;
            $display("FAIL compare_data got=%h required=%h", compare_data, pattern);
        end
        step();

        for (int w = 0; w < wait_cycles; w++) begin
            vectors++;
            if (filter_result_valid !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || result_reset !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_ctrl cyc=%0d frv=%0b m_valid=%0b s_ready=%0b rr=%0b required all 0",
                         w, filter_result_valid, m_valid, s_ready, result_reset);
            end
            vectors++;
            if (input_stream !== exp_win || compare_data !== pattern) begin
                miscompares++;
                $display("FAIL wait_hold cyc=%0d cmp=%h required=%h window_ok=%0b", w, compare_data, pattern,
                         input_stream === exp_win);
            end
            result_valid = (!exp_tmo && w == lat);
            result_match = (!exp_tmo && w == lat) ? mbit : 1'($urandom_range(0, 1));
            s_data = {$urandom, $urandom};
            step();
        end

        for (int d = 0; d <= rdy_delay; d++) begin
            vectors++;
            if (m_valid !== 1'b1 || m_match !== exp_match || m_timeout !== exp_tmo || m_record_id !== IDW'(exp_id)) begin
                miscompares++;
                $display("FAIL report cyc=%0d valid=%0b match=%0b tmo=%0b id=%0d required 1/%0b/%0b/%0d",
                         d, m_valid, m_match, m_timeout, m_record_id, exp_match, exp_tmo, exp_id);
            end
            vectors++;
            if (filter_result_valid !== 1'b0 || result_reset !== 1'b0 || s_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL report_ctrl frv=%0b rr=%0b s_ready=%0b required 0/0/0", filter_result_valid, result_reset, s_ready);
            end
            m_ready = (d == rdy_delay);
            result_valid = 1'($urandom_range(0, 1)); result_match = 1'($urandom_range(0, 1));
            step();
        end
        m_ready = 1'b0;
        result_valid = 1'b0;
        exp_records++;
        if (exp_match) exp_matches++;

        vectors++;
        if (result_reset !== 1'b1 || m_valid !== 1'b0 || s_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL release rr=%0b m_valid=%0b s_ready=%0b required 1/0/0", result_reset, m_valid, s_ready);
        end
        vectors++;
        if (stat_records !== 32'(exp_records) || stat_matches !== 32'(exp_matches)) begin
            miscompares++;
            $display("FAIL stats records=%0d matches=%0d required %0d/%0d", stat_records, stat_matches, exp_records, exp_matches);
        end
        step();
        s_valid = 1'b0;
        exp_id = (exp_id + 1) % (1 << IDW);
        vectors++;
        if (result_reset !== 1'b0 || s_ready !== 1'b1 || input_stream !== '0 || m_record_id !== IDW'(exp_id)) begin
            miscompares++;
            $display("FAIL back_to_load rr=%0b s_ready=%0b window_zero=%0b id=%0d required 0/1/1/%0d",
                     result_reset, s_ready, input_stream == '0, m_record_id, exp_id);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        vectors++;
        if (m_valid !== 1'b0 || filter_result_valid !== 1'b0 || result_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL in_reset m_valid=%0b frv=%0b rr=%0b required 0/0/0", m_valid, filter_result_valid, result_reset);
        end
        areset = 1'b0;
        step();
        exp_id = 0; exp_records = 0; exp_matches = 0;
        vectors++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0 || m_match !== 1'b0 || m_timeout !== 1'b0 ||
            m_record_id !== '0 || filter_result_valid !== 1'b0 || result_reset !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl s_ready=%0b m_valid=%0b match=%0b tmo=%0b id=%0d frv=%0b rr=%0b required 1/0/0/0/0/0/0",
                     s_ready, m_valid, m_match, m_timeout, m_record_id, filter_result_valid, result_reset);
        end
        vectors++;
        if (input_stream !== '0 || compare_data !== '0 || stat_records !== '0 || stat_matches !== '0) begin
            miscompares++;
            $display("FAIL reset_data window_zero=%0b cmp=%h rec=%0d mat=%0d required 1/0/0/0",
                     input_stream == '0, compare_data, stat_records, stat_matches);
        end
    endtask

    task automatic test_full_window();
        logic [DW-1:0] b;
        for (int k = 0; k < int'(NB); k++) begin
            for (int j = 0; j < 8; j++) b[j*8 +: 8] = 8'(8 * k + j);
            beat_buf[k] = b;
        end
        run_record(int'(NB), 1'b1, 64'h0F0E_0D0C_0B0A_0908, 9, 1'b1, 0, 1'b0);
    endtask

    task automatic test_short_record();
        for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
        run_record(3, 1'b1, {$urandom, $urandom}, 4, 1'b0, 1, 1'b0);
    endtask

    task automatic test_timeout();
        for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
        run_record(2, 1'b1, {$urandom, $urandom}, -1, 1'b1, 0, 1'b0);
        run_record(int'(NB), 1'b0, {$urandom, $urandom}, 0, 1'b1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
        run_record(5, 1'b1, {$urandom, $urandom}, 2, 1'b1, 20, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        bit saw_rr;
        saw_rr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = (k == 1);
            cfg_pattern = {$urandom, $urandom};
            step();
        end
        s_valid = 1'b0; s_last = 1'b0;
        step();
        for (int w = 0; w < 5; w++) begin
            if (result_reset !== 1'b0) saw_rr = 1'b1;
            step();
        end
        #3 areset = 1'b1;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || filter_result_valid !== 1'b0 || input_stream !== '0 || compare_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset m_valid=%0b frv=%0b window_zero=%0b cmp=%h required 0/0/1/0",
                     m_valid, filter_result_valid, input_stream == '0, compare_data);
        end
        @(posedge fclk);
        #1;
        if (result_reset !== 1'b0) saw_rr = 1'b1;
        areset = 1'b0;
        step();
        if (result_reset !== 1'b0) saw_rr = 1'b1;
        exp_id = 0; exp_records = 0; exp_matches = 0;
        vectors++;
        if (saw_rr || stat_records !== '0 || stat_matches !== '0 || m_record_id !== '0 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_wait rr_seen=%0b rec=%0d mat=%0d id=%0d s_ready=%0b required 0/0/0/0/1",
                     saw_rr, stat_records, stat_matches, m_record_id, s_ready);
        end
        for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
        run_record(4, 1'b1, {$urandom, $urandom}, 1, 1'b1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 20; r++) begin
            for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
            run_record(1, 1'b1, {$urandom, $urandom}, 0, 1'(r % 2), 0, 1'b0);
        end
    endtask

    task automatic test_random();
        int n;
        int lat;
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < int'(NB); k++) beat_buf[k] = {$urandom, $urandom};
            n   = $urandom_range(1, NB);
            lat = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, TMO - 1));
            run_record(n, 1'($urandom_range(0, 1)), {$urandom, $urandom}, lat,
                       1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b1);
        end
    endtask

    initial begin
        areset = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; cfg_pattern = '0;
        result_valid = 1'b0; result_match = 1'b0; m_ready = 1'b0;
        exp_id = 0; exp_records = 0; exp_matches = 0;
        test_reset();
        test_full_window();
        test_short_record();
        test_timeout();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/matcher_feeder.md
MATCHER_FEEDER -- requirements
Module: matcher_feeder

Interface
REQ-001 SHALL have parameter INPUT_STREAM_WIDTH, default 512: matcher window width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default 64: beat width and pattern width in bits.
REQ-003 SHALL have parameter ID_WIDTH, default 16: record identifier width.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting for the matcher.
REQ-005 SHALL have one clock and asynchronous active-high reset: fclk input 1 clock; areset input 1 reset, asynchronous assert.
REQ-006 SHALL have these record input ports: s_data input DATA_WIDTH record beat; s_valid input 1; s_last input 1 final beat of record; s_ready output 1.
REQ-007 SHALL have cfg_pattern input DATA_WIDTH: search pattern, sampled at record start.
REQ-008 SHALL have these matcher-facing ports: input_stream output INPUT_STREAM_WIDTH; compare_data output DATA_WIDTH; filter_result_valid output 1; result_valid input 1; result_match input 1; result_reset output 1.
REQ-009 SHALL have these result output ports: m_valid output 1; m_ready input 1; m_match output 1; m_timeout output 1; m_record_id output ID_WIDTH.
REQ-010 SHALL have these statistics ports: stat_records output 32; stat_matches output 32.

Function
REQ-011 SHALL implement FSM states LOAD, ISSUE, WAIT, REPORT, RELEASE.
REQ-012 LOAD: s_ready=1; beat k written to input_stream[DATA_WIDTH*k +: DATA_WIDTH]; beat counter counts 0..INPUT_STREAM_WIDTH/DATA_WIDTH-1.
REQ-013 LOAD exits to ISSUE on an accepted beat that is either the last window slot or carries s_last; beats beyond the window never occur because s_ready drops.
REQ-014 Unwritten window bytes SHALL read 0x00.
REQ-015 cfg_pattern SHALL be latched into compare_data on the first accepted beat of each record and held until RELEASE.
REQ-016 ISSUE: filter_result_valid=1 for exactly one cycle, then WAIT.
REQ-017 WAIT: on result_valid=1, latch result_match, clear the timeout flag and go to REPORT; input_stream and compare_data held stable.
REQ-018 WAIT: a wait counter counts cycles; at count == TIMEOUT, set m_timeout, force the match flag to 0 and go to REPORT.
REQ-019 REPORT: m_valid=1 with m_match, m_timeout and m_record_id stable; on m_valid&&m_ready go to RELEASE.
REQ-020 RELEASE: result_reset=1 for one cycle; window zeroed; beat counter cleared; record_id incremented (wraps at 2^ID_WIDTH); return to LOAD.
REQ-021 s_ready SHALL be 0 in every state except LOAD; no input beat is accepted outside LOAD.
REQ-022 stat_records SHALL increment on each REPORT handshake; stat_matches SHALL increment on each handshake with m_match=1; both saturate at 0xFFFFFFFF.
REQ-023 result_valid asserting outside WAIT SHALL be ignored.
REQ-024 Latency: last beat accepted at cycle N -> filter_result_valid at N+1 -> m_valid the cycle after result_valid is sampled.

Reset
REQ-025 On areset: state LOAD; s_ready=1 after reset release; all other outputs 0; input_stream, compare_data, record_id, counters and statistics cleared.
REQ-026 Reset mid-record SHALL discard the partial window and any pending result, and SHALL NOT pulse result_reset.

Structure
REQ-027 Package matcher_pkg SHALL hold the FSM state encoding, default widths and TIMEOUT default.
REQ-028 Beat accumulation and zero-fill SHALL live in sub-module matcher_window_loader; FSM, timeout and statistics stay in matcher_feeder.

Verification
REQ-029 8 beats 0x0706050403020100..0x3F3E3D3C3B3A3938, pattern 0x0F0E0D0C0B0A0908, matcher model returns match=1 after 10 cycles -> one filter_result_valid pulse; m_match=1, m_record_id=0; stat_matches=1.
REQ-030 3-beat record with s_last on beat 3 -> input_stream[511:192]=0; s_ready=0 from the cycle after beat 3 until RELEASE.
REQ-031 Matcher never asserts result_valid -> m_timeout=1, m_match=0 after TIMEOUT+1 cycles in WAIT; result_reset pulses after handshake.
REQ-032 m_ready held low 20 cycles in REPORT -> m_valid and outputs stable throughout; single RELEASE pulse afterwards.
REQ-033 areset asserted during WAIT -> next record reports m_record_id=0; no result_reset seen; statistics=0.
REQ-034 Run 65537 records with ID_WIDTH=16 -> record_id wraps from 0xFFFF to 0; stat_records=65537.
